// File: rtl/stream_scheduler_pkg.sv
// Shared types and defaults for the I2S-to-SPDIF stream scheduler.
// Holds the FSM state encoding, default sizing constants and the LED decode.
package stream_scheduler_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    PRIME     = 2'd1,
    RUN       = 2'd2,
    RECOVER   = 2'd3
  } state_e;

  localparam int DEFAULT_DEPTH       = 16;
  localparam int DEFAULT_PRIME_LEVEL = 8;
  localparam int DEFAULT_LOCK_WAIT   = 1024;
  localparam int CNT_W               = 8;

  // Active-low LED pattern {red, green, blue} for a given state.
  function automatic logic [2:0] led_pattern(state_e s);
    logic [2:0] leds;
    leds = 3'b111;
    case (s)
      WAIT_LOCK:     leds = 3'b011;
      RUN:           leds = 3'b101;
      PRIME, RECOVER: leds = 3'b110;
      default:       leds = 3'b111;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/stream_scheduler_sat_counter.sv
// Saturating up-counter used for overrun/underrun event statistics.
// Holds at all-ones; cleared by synchronous active-low reset or clear_i.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/stream_scheduler.sv
// Schedules FIFO pushes from an I2S receiver and pops for an SPDIF transmitter,
// gating playback on PLL lock and a priming threshold, with overrun/underrun stats.
module stream_scheduler
  import stream_scheduler_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PRIME_LEVEL = DEFAULT_PRIME_LEVEL,
  parameter int LOCK_WAIT   = DEFAULT_LOCK_WAIT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pll_lock,
  input  logic                       fclk_edge,
  input  logic                       frame_req,
  input  logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       write_en,
  output logic                       read_en,
  output logic                       validity,
  output logic                       mute,
  output logic [CNT_W-1:0]           overrun_cnt,
  output logic [CNT_W-1:0]           underrun_cnt,
  output logic                       red,
  output logic                       green,
  output logic                       blue
);

  localparam int LW  = $clog2(DEPTH + 1);
  localparam int LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [LW-1:0]  DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0]  PRIME_L   = LW'(PRIME_LEVEL);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

  state_e         state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           write_en_q, write_en_d;
  logic           read_en_q, read_en_d;
  logic           validity_q, validity_d;
  logic           mute_q, mute_d;
  logic           read_grant;
  logic           overrun_inc;
  logic           underrun_inc;
  logic [2:0]     leds;

  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    write_en_d   = 1'b0;
    read_en_d    = 1'b0;
    read_grant   = 1'b0;
    overrun_inc  = 1'b0;
    underrun_inc = 1'b0;

    if (state_q == WAIT_LOCK) begin
      if (!pll_lock) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_LAST) begin
        state_d = PRIME;
      end else begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
      end
    end else if (!pll_lock) begin
      // Losing lock drops everything this cycle, including pending strobes.
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
    end else begin
      if (state_q == RUN) begin
        if (frame_req) begin
          if (level != '0) begin
            read_grant = 1'b1;
          end else begin
            underrun_inc = 1'b1;
            state_d      = RECOVER;
          end
        end
      end else if (level >= PRIME_L) begin
        state_d = RUN;
      end

      // A full FIFO still accepts a write when a pop happens in the same cycle.
      if (fclk_edge) begin
        if ((level < DEPTH_L) || ((level == DEPTH_L) && read_grant)) begin
          write_en_d = 1'b1;
        end else begin
          overrun_inc = 1'b1;
        end
      end
      read_en_d = read_grant;
    end

    validity_d = (state_d == RUN);
    mute_d     = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      validity_q <= 1'b0;
      mute_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      write_en_q <= write_en_d;
      read_en_q  <= read_en_d;
      validity_q <= validity_d;
      mute_q     <= mute_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_overrun_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (1'b0),
    .inc_i   (overrun_inc),
    .count_o (overrun_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_underrun_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (1'b0),
    .inc_i   (underrun_inc),
    .count_o (underrun_cnt)
  );

  assign leds     = led_pattern(state_q);
  assign red      = leds[2];
  assign green    = leds[1];
  assign blue     = leds[0];
  assign write_en = write_en_q;
  assign read_en  = read_en_q;
  assign validity = validity_q;
  assign mute     = mute_q;

endmodule
